mem_maint_ctl: RTL

Parametrised memory-maintenance sequencer. It replaces the fixed single-cycle flush/clear decode in the CU test harness. It accepts one maintenance request at a time (FENCE.I, SFENCE.VMA or a committed exception) and sequences a fixed set of actions: MSHR clears, L1D→L2 synchronisation with timeout, and a per-level TLB flush over N_TLB levels. It sits between the CU/commit logic and the TLBs, PTW and d-cache updating unit, and stalls the front end while busy.

---
 rtl/mem_maint_ctl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_maint_ctl.sv
// Memory-maintenance sequencer: takes one FENCE.I / SFENCE.VMA / exception request at a time
// and steps through MSHR clears, L1D->L2 sync (with timeout) and a per-level TLB flush.
module mem_maint_ctl #(
  parameter int N_TLB        = 2,
  parameter int ASID_LEN     = 16,
  parameter int VPN_LEN      = 27,
  parameter int SYNC_TIMEOUT = 64,
  parameter int FLUSH_HOLD   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_type_i,
  input  logic [3:0]            except_code_i,
  input  logic                  sfence_rs1_zero_i,
  input  logic                  sfence_rs2_zero_i,
  input  logic [ASID_LEN-1:0]   asid_i,
  input  logic [VPN_LEN-1:0]    vpn_i,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  abort_o,
  output logic [N_TLB-1:0]      clr_tlb_mshr_o,
  output logic                  clr_dmshr_o,
  output logic                  sync_req_o,
  input  logic                  sync_done_i,
  output logic [2*N_TLB-1:0]    tlb_flush_type_o,
  output logic [ASID_LEN-1:0]   flush_asid_o,
  output logic [VPN_LEN-1:0]    flush_vpn_o,
  output logic                  done_o,
  output logic                  timeout_o
);

  localparam int CNT_W  = $clog2(SYNC_TIMEOUT + 1);
  localparam int LVL_W  = (N_TLB > 1) ? $clog2(N_TLB) : 1;
  localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

  localparam logic [1:0] FT_NONE = 2'd0;
  localparam logic [1:0] FT_PAGE = 2'd1;
  localparam logic [1:0] FT_ASID = 2'd2;
  localparam logic [1:0] FT_ALL  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SYNC, S_FLUSH, S_DONE
  } state_e;

  // Decoded action set, registered at accept so the sequence never looks at live inputs.
  typedef struct packed {
    logic       clr_tlb;
    logic       clr_d;
    logic       abort;
    logic       sync;
    logic [1:0] ftype;
    logic       is_exc;
  } action_t;

  state_e              state_q, state_d;
  action_t             act_q, act_d, dec;
  logic [ASID_LEN-1:0] asid_q, asid_d;
  logic [VPN_LEN-1:0]  vpn_q, vpn_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [1:0]          after_sync_ft;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    dec = '0;
    unique case (req_type_i)
      2'd0: dec.clr_tlb = 1'b1;
      2'd1: begin
        dec.clr_tlb = 1'b1;
        dec.clr_d   = 1'b1;
        dec.sync    = 1'b1;
        if (!sfence_rs1_zero_i)     dec.ftype = FT_PAGE;
        else if (sfence_rs2_zero_i) dec.ftype = FT_ALL;
        else                        dec.ftype = FT_ASID;
      end
      2'd2: begin
        dec.is_exc = 1'b1;
        case (except_code_i)
          4'd0, 4'd1:        dec.clr_tlb = 1'b1;
          4'd12:             begin dec.clr_tlb = 1'b1; dec.ftype = FT_PAGE; end
          4'd4, 4'd5,
          4'd6, 4'd7:        dec.clr_d = 1'b1;
          4'd13, 4'd15:      begin dec.clr_d = 1'b1; dec.ftype = FT_PAGE; end
          4'd2:              dec.abort = 1'b1;
          4'd9, 4'd11:       dec.sync = 1'b1;
          default:           dec = dec;
        endcase
      end
      default: dec = '0;
    endcase
  end

  assign after_sync_ft = act_q.ftype;

  always_comb begin
    state_d          = state_q;
    act_d            = act_q;
    asid_d           = asid_q;
    vpn_d            = vpn_q;
    cnt_d            = cnt_q;
    lvl_d            = lvl_q;
    hold_d           = hold_q;
    req_ready_o      = 1'b0;
    stall_o          = 1'b1;
    flush_o          = 1'b0;
    abort_o          = 1'b0;
    clr_tlb_mshr_o   = '0;
    clr_dmshr_o      = 1'b0;
    sync_req_o       = 1'b0;
    tlb_flush_type_o = '0;
    flush_asid_o     = '0;
    flush_vpn_o      = '0;
    done_o           = 1'b0;
    timeout_o        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        stall_o     = 1'b0;
        if (req_valid_i) begin
          act_d   = dec;
          asid_d  = asid_i;
          vpn_d   = vpn_i;
          state_d = (req_type_i == 2'd3) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_tlb_mshr_o = {N_TLB{act_q.clr_tlb}};
        clr_dmshr_o    = act_q.clr_d;
        abort_o        = act_q.abort;
        if (act_q.sync)                 state_d = S_SYNC;
        else if (act_q.ftype != FT_NONE) state_d = S_FLUSH;
        else                            state_d = S_DONE;
      end
      S_SYNC: begin
        // The counter reaching SYNC_TIMEOUT means that many request cycles went unanswered.
        if (int'(cnt_q) == SYNC_TIMEOUT) begin
          timeout_o = 1'b1;
          cnt_d     = '0;
          state_d   = (after_sync_ft != FT_NONE) ? S_FLUSH : S_DONE;
        end else begin
          sync_req_o = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (sync_done_i) begin
            cnt_d   = '0;
            state_d = (after_sync_ft != FT_NONE) ? S_FLUSH : S_DONE;
          end
        end
      end
      S_FLUSH: begin
        flush_asid_o = asid_q;
        flush_vpn_o  = vpn_q;
        for (int i = 0; i < N_TLB; i++) begin
          if (int'(lvl_q) == i) tlb_flush_type_o[2*i +: 2] = act_q.ftype;
        end
        hold_d = hold_q + HOLD_W'(1);
        if (int'(hold_q) == FLUSH_HOLD - 1) begin
          hold_d = '0;
          if (int'(lvl_q) == N_TLB - 1) begin
            lvl_d   = '0;
            state_d = S_DONE;
          end else begin
            lvl_d = lvl_q + LVL_W'(1);
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        flush_o = act_q.is_exc;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      act_q   <= '0;
      asid_q  <= '0;
      vpn_q   <= '0;
      cnt_q   <= '0;
      lvl_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      asid_q  <= asid_d;
      vpn_q   <= vpn_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      hold_q  <= hold_d;
    end
  end

endmodule
